// File: rtl/accum_rr_sequencer_if.sv
// accum_rr_sequencer_if: requester handshakes and shared adder operands/result
interface accum_rr_sequencer_if #(
    parameter int WIDTH = 5
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;
    logic [WIDTH-1:0] add_in1;
    logic [WIDTH-1:0] add_in2;
    logic [WIDTH-1:0] add_out;
    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, add_out,
        output req0_ready, req1_ready, add_in1, add_in2
    );
    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, add_out,
        input  req0_ready, req1_ready, add_in1, add_in2
    );
endinterface

// File: rtl/accum_rr_sequencer.sv
// accum_rr_sequencer: round-robin feeds len operands through a shared adder into an accumulator
module accum_rr_sequencer #(
    parameter int WIDTH = 5,
    parameter int LEN_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [LEN_W-1:0]     len_i,
    accum_rr_sequencer_if.slave  bus,
    output logic [WIDTH-1:0]     acc_out_o,
    output logic                 ovf_o,
    output logic                 busy_o,
    output logic                 done_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             ovf_q, ovf_d;
    logic             ptr_q, ptr_d;
    logic             run, g0, g1, xfer;
    always_comb begin
        run = state_q == RUN;
        g0 = run & bus.req0_valid & (~bus.req1_valid | ~ptr_q);
        g1 = run & bus.req1_valid & (~bus.req0_valid | ptr_q);
        xfer = g0 | g1;
        bus.req0_ready = g0;
        bus.req1_ready = g1;
        bus.add_in1 = acc_q;
        bus.add_in2 = g0 ? bus.req0_data : g1 ? bus.req1_data : '0;
        acc_out_o = acc_q;
        ovf_o = ovf_q;
        busy_o = run;
        done_o = state_q == DONE;
    end
    always_comb begin
        state_d = state_q;
        acc_d = acc_q;
        rem_d = rem_q;
        ovf_d = ovf_q;
        ptr_d = ptr_q;
        unique case (state_q)
            IDLE: if (start_i) begin
                acc_d = '0;
                ovf_d = 1'b0;
                rem_d = len_i;
                ptr_d = 1'b0;
                state_d = (len_i != '0) ? RUN : DONE;
            end
            RUN: if (xfer) begin
                acc_d = bus.add_out;
                ovf_d = ovf_q | (bus.add_out < acc_q);
                rem_d = rem_q - 1'b1;
                ptr_d = g0;
                state_d = (rem_q == LEN_W'(1)) ? DONE : RUN;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q <= '0;
            rem_q <= '0;
            ovf_q <= 1'b0;
            ptr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q <= acc_d;
            rem_q <= rem_d;
            ovf_q <= ovf_d;
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: tb/tb_accum_rr_sequencer.sv
// tb_accum_rr_sequencer: directed steps with hand-computed expectations
module tb_accum_rr_sequencer;
  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [3:0] len;
  logic [4:0] acc_out;
  logic ovf, busy, done;
  int checks = 0;
  int errors = 0;
  accum_rr_sequencer_if #(.WIDTH(5)) bus ();
  assign bus.add_out = bus.add_in1 + bus.add_in2;
  accum_rr_sequencer #(.WIDTH(5), .LEN_W(4)) dut (
    .clk(clk), .rst(rst), .start_i(start), .len_i(len), .bus(bus),
    .acc_out_o(acc_out), .ovf_o(ovf), .busy_o(busy), .done_o(done)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    if (o !== e) begin
      errors++;
      $error("FAIL %s got %0d want %0d", tag, o, e);
    end
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; len = 4'd0;
    bus.req0_valid = 1'b1; bus.req0_data = 5'd9;
    bus.req1_valid = 1'b0; bus.req1_data = 5'd0;
    step(); step();
    chk("rst_acc", acc_out, 5'd0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rdy0", bus.req0_ready, 1'b0);
    chk("rst_rdy1", bus.req1_ready, 1'b0);
    chk("rst_in2", bus.add_in2, 5'd0);
    rst = 1'b0; bus.req0_valid = 1'b0;
    step();
    start = 1'b1; len = 4'd3;
    step();
    start = 1'b0; bus.req0_valid = 1'b1; bus.req0_data = 5'd7;
    #1;
    chk("mr_busy", busy, 1'b1);
    chk("mr_rdy0", bus.req0_ready, 1'b1);
    chk("mr_in2", bus.add_in2, 5'd7);
    step();
    chk("mr_acc7", acc_out, 5'd7);
    rst = 1'b1;
    step();
    chk("mr_acc0", acc_out, 5'd0);
    chk("mr_busy0", busy, 1'b0);
    chk("mr_rdy0_off", bus.req0_ready, 1'b0);
    chk("mr_nodone", done, 1'b0);
    rst = 1'b0;
    step();
    chk("mr_nodone2", done, 1'b0);
    chk("mr_idle", busy, 1'b0);
    bus.req0_data = 5'd5; start = 1'b1; len = 4'd3;
    step();
    start = 1'b0;
    #1;
    chk("s_busy1", busy, 1'b1);
    chk("s_rdy", bus.req0_ready, 1'b1);
    chk("s_in1", bus.add_in1, 5'd0);
    chk("s_in2", bus.add_in2, 5'd5);
    step();
    chk("s_acc5", acc_out, 5'd5);
    chk("s_busy2", busy, 1'b1);
    bus.req0_data = 5'd9;
    step();
    chk("s_acc14", acc_out, 5'd14);
    chk("s_busy3", busy, 1'b1);
    chk("s_nodone", done, 1'b0);
    bus.req0_data = 5'd2;
    step();
    chk("s_acc16", acc_out, 5'd16);
    chk("s_done", done, 1'b1);
    chk("s_busy_off", busy, 1'b0);
    chk("s_ovf", ovf, 1'b0);
    chk("s_rdy_done", bus.req0_ready, 1'b0);
    bus.req0_valid = 1'b0;
    step();
    chk("s_done_pulse", done, 1'b0);
    chk("s_hold", acc_out, 5'd16);
    bus.req0_valid = 1'b1; bus.req0_data = 5'd10;
    bus.req1_valid = 1'b1; bus.req1_data = 5'd3;
    start = 1'b1; len = 4'd4;
    step();
    start = 1'b0;
    #1;
    chk("rr_g1_r0", bus.req0_ready, 1'b1);
    chk("rr_g1_r1", bus.req1_ready, 1'b0);
    step();
    chk("rr_acc10", acc_out, 5'd10);
    chk("rr_g2_r0", bus.req0_ready, 1'b0);
    chk("rr_g2_r1", bus.req1_ready, 1'b1);
    chk("rr_g2_in2", bus.add_in2, 5'd3);
    step();
    chk("rr_acc13", acc_out, 5'd13);
    chk("rr_g3_r0", bus.req0_ready, 1'b1);
    chk("rr_g3_r1", bus.req1_ready, 1'b0);
    step();
    chk("rr_acc23", acc_out, 5'd23);
    chk("rr_g4_r0", bus.req0_ready, 1'b0);
    chk("rr_g4_r1", bus.req1_ready, 1'b1);
    step();
    chk("rr_acc26", acc_out, 5'd26);
    chk("rr_ovf", ovf, 1'b0);
    chk("rr_done", done, 1'b1);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    step();
    bus.req1_valid = 1'b1; bus.req1_data = 5'd20;
    start = 1'b1; len = 4'd2;
    step();
    start = 1'b0;
    #1;
    chk("ov_rdy1", bus.req1_ready, 1'b1);
    step();
    chk("ov_acc20", acc_out, 5'd20);
    chk("ov_ovf0", ovf, 1'b0);
    bus.req1_data = 5'd15;
    step();
    chk("ov_acc3", acc_out, 5'd3);
    chk("ov_ovf1", ovf, 1'b1);
    chk("ov_done", done, 1'b1);
    bus.req1_valid = 1'b0;
    step();
    chk("ov_hold", ovf, 1'b1);
    bus.req0_valid = 1'b1; bus.req0_data = 5'd4;
    start = 1'b1; len = 4'd1;
    step();
    start = 1'b0;
    #1;
    chk("ov_clear", ovf, 1'b0);
    chk("ov_acc_clear", acc_out, 5'd0);
    step();
    chk("ov_acc4", acc_out, 5'd4);
    chk("ov_ovf_new", ovf, 1'b0);
    chk("ov_done2", done, 1'b1);
    bus.req0_valid = 1'b0;
    step();
    start = 1'b1; len = 4'd2;
    step();
    start = 1'b0; bus.req0_valid = 1'b1; bus.req0_data = 5'd6;
    #1;
    chk("st_rdy_c1", bus.req0_ready, 1'b1);
    step();
    bus.req0_valid = 1'b0;
    #1;
    chk("st_acc6", acc_out, 5'd6);
    chk("st_stall_rdy", bus.req0_ready, 1'b0);
    chk("st_stall_in2", bus.add_in2, 5'd0);
    chk("st_busy", busy, 1'b1);
    step();
    start = 1'b1; len = 4'd5;
    step();
    start = 1'b0;
    chk("st_acc_hold", acc_out, 5'd6);
    chk("st_busy_c4", busy, 1'b1);
    step();
    bus.req0_valid = 1'b1; bus.req0_data = 5'd11;
    #1;
    chk("st_rdy_c5", bus.req0_ready, 1'b1);
    step();
    chk("st_acc17", acc_out, 5'd17);
    chk("st_done", done, 1'b1);
    bus.req0_valid = 1'b0;
    step();
    chk("st_done_once", done, 1'b0);
    chk("st_no_requeue", busy, 1'b0);
    step();
    chk("st_still_idle", busy, 1'b0);
    chk("st_acc_final", acc_out, 5'd17);
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    start = 1'b1; len = 4'd0;
    #1;
    chk("z_rdy0_idle", bus.req0_ready, 1'b0);
    step();
    start = 1'b0;
    chk("z_done", done, 1'b1);
    chk("z_acc", acc_out, 5'd0);
    chk("z_busy", busy, 1'b0);
    chk("z_rdy0", bus.req0_ready, 1'b0);
    chk("z_rdy1", bus.req1_ready, 1'b0);
    step();
    chk("z_done_off", done, 1'b0);
    chk("z_rdy0_after", bus.req0_ready, 1'b0);
    chk("z_rdy1_after", bus.req1_ready, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/accum_rr_sequencer.md
Name: accum_rr_sequencer

Overview:
- Sequences the shared 5-bit accumulator adder (combinational, sum = in1 + in2 mod 32) through a run of `len` additions.
- Operands come from two requester ports, arbitrated round-robin with valid/ready handshakes.
- Holds the running sum in its accumulator register and drives both adder operands.
- Reports the final sum, a sticky unsigned-overflow flag and a one-cycle done pulse.

Parameters:
- WIDTH, 5, datapath width; must match the adder width.
- LEN_W, 4, width of the operand-count input (runs of 1..15 operands).

Ports:
- clk  input  1  system clock, all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a run; sampled only in IDLE.
- len  input  LEN_W  number of operands to accumulate; sampled with start.
- req0_valid  input  1  requester 0 has an operand.
- req0_data  input  WIDTH  requester 0 operand.
- req0_ready  output  1  requester 0 operand accepted this cycle.
- req1_valid  input  1  requester 1 has an operand.
- req1_data  input  WIDTH  requester 1 operand.
- req1_ready  output  1  requester 1 operand accepted this cycle.
- add_in1  output  WIDTH  adder operand A (current accumulator).
- add_in2  output  WIDTH  adder operand B (granted operand, else 0).
- add_out  input  WIDTH  adder result.
- acc_out  output  WIDTH  accumulator value.
- ovf  output  1  sticky: some addition in this run wrapped past 2^WIDTH-1.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when a run completes.

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, acc=0, remaining=0, ovf=0, rr_ptr=0, done=0. Outputs after reset:
  - acc_out=0, ovf=0, busy=0, done=0.
  - req0_ready=0, req1_ready=0, add_in2=0.
- Reset takes priority over everything, including mid-run. A run interrupted by reset is abandoned; there is no done.
- States: IDLE, RUN, DONE.
- IDLE, start=1, len!=0: next cycle acc=0, ovf=0, remaining=len, rr_ptr=0, state=RUN.
- IDLE, start=1, len=0: next cycle acc=0, ovf=0, state=DONE. This is a zero-length run.
- IDLE, start=0: hold state; acc_out keeps the last result.
- RUN, grant rule (combinational, at most one ready high per cycle):
  - Only one requester valid: it is granted.
  - Both valid: requester rr_ptr is granted.
  - Neither valid: no grant, and the cycle is a stall.
  - reqN_ready = RUN and granted N. Ready never depends on ready.
- RUN, on a transfer (valid & ready):
  - acc <= add_out.
  - ovf <= ovf | (add_out < acc), unsigned compare.
  - remaining <= remaining-1.
  - rr_ptr <= opposite of the granted requester.
- If the transfer happens with remaining==1: state=DONE.
- Throughput: one operand per cycle. Latency: sum visible on acc_out the cycle after the transfer.
- Stall cycles change nothing except that add_in2=0.
- add_in1=acc at all times. add_in2=granted data, else 0.
- DONE: done=1 for exactly this cycle; acc_out and ovf hold the final values; next state=IDLE.
- start is ignored in RUN and DONE. It is not queued.
- A requester that is valid but not granted keeps its valid high and its data stable. The sequencer never drops an operand that was not acknowledged.
- Arithmetic is modulo 2^WIDTH. No saturation.

Test Plan:
- Reset mid-run: start len=3, one transfer of 7, then rst=1 -> next cycle acc_out=0, busy=0, ready=0, no done pulse.
- Single requester, exact values: len=3, req0 sends 5, 9, 2 back to back -> acc_out=16, ovf=0, done pulses 1 cycle after the third transfer, busy high for exactly 3 cycles.
- Round-robin contention, overflow check: len=4, both valid continuously, req0 always 10, req1 always 3.
  - Grants go req0, req1, req0, req1.
  - Final acc_out = 26, ovf=0; each requester sees ready on alternate cycles.
- Overflow and wrap: len=2, req1 sends 20, then 15 -> acc_out=3 (35 mod 32), ovf=1. Next run with len=1 and operand 4 -> acc_out=4, ovf=0.
- Stalls and ignored start: len=2, req0 valid only on cycles 1 and 5, start pulsed again in cycle 3 -> acc_out = sum of the 2 operands, done once, second start has no effect.
- Zero length: start with len=0 -> one cycle later done=1, acc_out=0, both readies never asserted.
